// File: rtl/chan_select_mux.sv
// Channel select mux: explicit-select or round-robin grant into a one-word registered output slot.
// Optional macro CHAN_SELECT_MUX_COUNT_EN adds a saturating 16-bit transfer counter (xfer_count).
module chan_select_mux #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 8,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
`ifdef CHAN_SELECT_MUX_COUNT_EN
   output logic [15:0]               xfer_count,
`endif
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [SEL_W-1:0] ptr_r;
   logic [SEL_W-1:0] gidx_s;
   logic             found_s;
   logic             space_s;
   logic             grant_s;
   int               idx_s;

   // Pick a candidate channel: a sel that matches an index (out-of-range sel matches none), or the first valid after ptr.
   always_comb begin
      found_s = 1'b0;
      gidx_s  = '0;
      idx_s   = 0;
      if (mode == 1'b0) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (int'(sel) == i && in_valid[i]) begin
               found_s = 1'b1;
               gidx_s  = SEL_W'(i);
            end else begin
               found_s = found_s;
            end
         end
      end else begin
         for (int k = 1; k <= CHANNELS; k++) begin
            idx_s = (int'(ptr_r) + k) % CHANNELS;
            if (!found_s && in_valid[idx_s]) begin
               found_s = 1'b1;
               gidx_s  = SEL_W'(idx_s);
            end else begin
               found_s = found_s;
            end
         end
      end
   end

   // Grant only when the output slot has room and reset is not asserted.
   always_comb begin
      space_s  = !out_valid || out_ready;
      grant_s  = found_s && space_s && !reset;
      in_ready = '0;
      if (grant_s) begin
         in_ready[gidx_s] = 1'b1;
      end else begin
         in_ready = '0;
      end
   end

   // Output slot: load on grant (no bubble when draining), clear on drain-only, hold under backpressure.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_chan  <= '0;
         ptr_r     <= SEL_W'(CHANNELS - 1);
      end else if (grant_s) begin
         out_valid <= 1'b1;
         out_data  <= in_data[int'(gidx_s)*WIDTH +: WIDTH];
         out_chan  <= gidx_s;
         ptr_r     <= gidx_s;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= out_valid;
      end
   end

`ifdef CHAN_SELECT_MUX_COUNT_EN
   // Saturating count of delivered words.
   always_ff @(posedge clk) begin
      if (reset) begin
         xfer_count <= 16'h0000;
      end else if (out_valid && out_ready && xfer_count != 16'hFFFF) begin
         xfer_count <= xfer_count + 16'h0001;
      end else begin
         xfer_count <= xfer_count;
      end
   end
`endif

endmodule

// File: tb/tb_chan_select_mux.sv
// Directed self-checking bench for chan_select_mux (CHANNELS=8, WIDTH=8).
module tb_chan_select_mux;

   logic        clk;
   logic        reset;
   logic [63:0] in_data;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic        mode;
   logic [2:0]  sel;
   logic [7:0]  out_data;
   logic [2:0]  out_chan;
   logic        out_valid;
   logic        out_ready;
`ifdef CHAN_SELECT_MUX_COUNT_EN
   logic [15:0] xfer_count;
`endif

   logic [7:0] words [8];
   int checks;
   int errors;

   chan_select_mux #(.WIDTH(8), .CHANNELS(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
`ifdef CHAN_SELECT_MUX_COUNT_EN
      .xfer_count(xfer_count),
`endif
      .out_data  (out_data),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = words[i];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int i = 0; i < 8; i++) words[i] = 8'h10 + 8'(i);
      words[5]  = 8'hA5;
      reset     = 1'b1;
      mode      = 1'b1;
      sel       = 3'd0;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_data", 64'(out_data), 64'h0);
      chk("rst_out_chan", 64'(out_chan), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h0);

      // Explicit select of channel 5
      reset = 1'b0;
      mode  = 1'b0;
      sel   = 3'd5;
      #1;
      chk("sel5_in_ready", 64'(in_ready), 64'h20);
      tick();
      chk("sel5_out_data", 64'(out_data), 64'hA5);
      chk("sel5_out_chan", 64'(out_chan), 64'h5);
      chk("sel5_out_valid", 64'(out_valid), 64'h1);

      // Round-robin fairness from reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mode  = 1'b1;
      #1;
      for (int k = 0; k < 9; k++) begin
         chk("rr_in_ready", 64'(in_ready), 64'(8'h01 << (k % 8)));
         tick();
         chk("rr_out_chan", 64'(out_chan), 64'(k % 8));
         chk("rr_out_data", 64'(out_data), 64'(words[k % 8]));
         chk("rr_out_valid", 64'(out_valid), 64'h1);
      end

      // Park ptr at 6 via explicit select, then sparse round-robin wrap
      mode = 1'b0;
      sel  = 3'd6;
      tick();
      chk("park6_out_chan", 64'(out_chan), 64'h6);
      mode     = 1'b1;
      in_valid = 8'b0000_0101;
      #1;
      chk("wrap_g0_in_ready", 64'(in_ready), 64'h01);
      tick();
      chk("wrap_g0_chan", 64'(out_chan), 64'h0);
      chk("wrap_g2_in_ready", 64'(in_ready), 64'h04);
      tick();
      chk("wrap_g2_chan", 64'(out_chan), 64'h2);
      tick();
      chk("wrap_g0b_chan", 64'(out_chan), 64'h0);
      chk("wrap_g0b_data", 64'(out_data), 64'h10);

      // Backpressure: hold ch0 word for 3 cycles, ch2 pending
      out_ready = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("bp_in_ready", 64'(in_ready), 64'h0);
         tick();
         chk("bp_out_data", 64'(out_data), 64'h10);
         chk("bp_out_chan", 64'(out_chan), 64'h0);
         chk("bp_out_valid", 64'(out_valid), 64'h1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", 64'(in_ready), 64'h04);
      tick();
      chk("bp_release_chan", 64'(out_chan), 64'h2);
      chk("bp_release_data", 64'(out_data), 64'h12);

      // Drain with nothing pending empties the slot
      in_valid = 8'h00;
      tick();
      chk("drain_out_valid", 64'(out_valid), 64'h0);

      // Reset mid-operation discards held 3C word
      words[3]  = 8'h3C;
      mode      = 1'b0;
      sel       = 3'd3;
      in_valid  = 8'h08;
      out_ready = 1'b0;
      tick();
      chk("mid_load_data", 64'(out_data), 64'h3C);
      chk("mid_load_valid", 64'(out_valid), 64'h1);
      reset = 1'b1;
      #1;
      chk("mid_rst_in_ready", 64'(in_ready), 64'h0);
      tick();
      chk("mid_rst_valid", 64'(out_valid), 64'h0);
      chk("mid_rst_data", 64'(out_data), 64'h0);
      reset     = 1'b0;
      mode      = 1'b1;
      in_valid  = 8'hFF;
      out_ready = 1'b1;
      #1;
      chk("mid_rr_in_ready", 64'(in_ready), 64'h01);
      tick();
      chk("mid_rr_chan", 64'(out_chan), 64'h0);

`ifdef CHAN_SELECT_MUX_COUNT_EN
      // Counter: 5 transfers, then run to saturation
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("cnt_reset", 64'(xfer_count), 64'h0);
      for (int k = 0; k < 6; k++) tick();
      chk("cnt_five", 64'(xfer_count), 64'h5);
      for (int k = 0; k < 65530; k++) tick();
      chk("cnt_full", 64'(xfer_count), 64'hFFFF);
      for (int k = 0; k < 3; k++) tick();
      chk("cnt_saturate", 64'(xfer_count), 64'hFFFF);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/chan_select_mux.md
CHAN_SELECT_MUX -- requirements
Module: chan_select_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, bits per channel word.
REQ-002 The block SHALL have parameter CHANNELS, default 8, number of input channels; legal range 2..64.
REQ-003 The block SHALL have derived parameter SEL_W = $clog2(CHANNELS), the select and channel-ID width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-005 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port in_data, input, CHANNELS*WIDTH, channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid, input, CHANNELS, per-channel word-present flag.
REQ-008 The block SHALL have port in_ready, output, CHANNELS, per-channel accept strobe; at most one bit high per cycle.
REQ-009 The block SHALL have port mode, input, 1, 0 = explicit select, 1 = round-robin.
REQ-010 The block SHALL have port sel, input, SEL_W, channel index used when mode = 0.
REQ-011 The block SHALL have port out_data, output, WIDTH, registered selected word.
REQ-012 The block SHALL have port out_chan, output, SEL_W, source channel of out_data.
REQ-013 The block SHALL have port out_valid, output, 1, out_data/out_chan hold an undelivered word.
REQ-014 The block SHALL have port out_ready, input, 1, downstream accepts the word when high with out_valid.

Function
REQ-015 The block SHALL hold one output word; space = !out_valid || out_ready, evaluated combinationally each cycle.
REQ-016 In mode 0 the block SHALL grant channel sel iff in_valid[sel] and space and sel < CHANNELS; all other in_ready bits 0.
REQ-017 In mode 0 with sel >= CHANNELS the block SHALL grant nothing and drive in_ready all 0.
REQ-018 In mode 1 the block SHALL grant the first channel with in_valid set, searching from ptr+1 upward and wrapping CHANNELS-1 -> 0, iff space.
REQ-019 in_ready[g] SHALL be high for the granted channel g only; with no space or no valid channel in_ready SHALL be all 0.
REQ-020 On a grant the block SHALL load out_data <= word g, out_chan <= g, out_valid <= 1 at the next posedge; latency exactly 1 cycle.
REQ-021 On out_valid && out_ready with no grant in the same cycle, the block SHALL clear out_valid at the next posedge.
REQ-022 On simultaneous drain and grant the block SHALL replace the word with no bubble, so out_valid stays 1 and sustains one word per cycle.
REQ-023 While out_valid && !out_ready the block SHALL hold out_data and out_chan stable.
REQ-024 Register ptr SHALL update to g on every grant in either mode and hold otherwise.
REQ-025 mode and sel SHALL be sampled every cycle; a mode change SHALL take effect the same cycle without disturbing the held word.

Reset
REQ-026 While reset is high at posedge clk the block SHALL set out_valid = 0, out_data = 0, out_chan = 0 and ptr = CHANNELS-1, so the first round-robin search starts at channel 0.
REQ-027 During a reset cycle in_ready SHALL be all 0.
REQ-028 Reset mid-operation SHALL discard any held word without delivery.

Configuration
REQ-029 With macro CHAN_SELECT_MUX_COUNT_EN defined, the block SHALL add output xfer_count, 16 bits, incremented on each out_valid && out_ready, saturating at 16'hFFFF, cleared by reset.
REQ-030 With CHAN_SELECT_MUX_COUNT_EN undefined, xfer_count and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-031 The bench SHALL cover explicit select: CHANNELS=8, WIDTH=8, mode 0, sel=5, in_data ch5=8'hA5, all valid, out_ready=1 -> in_ready=8'b00100000; next cycle out_data=A5, out_chan=5, out_valid=1.
REQ-032 The bench SHALL cover round-robin fairness: mode 1, in_valid=8'hFF held, out_ready=1 after reset -> grants 0,1,2,...,7,0 on consecutive cycles with out_valid continuously 1.
REQ-033 The bench SHALL cover sparse wrap: mode 1, ptr=6, in_valid=8'b00000101 -> grant ch0, then ch2, then ch0.
REQ-034 The bench SHALL cover backpressure: word held, out_ready=0 for 3 cycles -> in_ready=0 and out_data/out_chan unchanged; out_ready=1 -> pending channel granted the same cycle, new word next cycle.
REQ-035 The bench SHALL cover reset mid-operation: out_valid=1 with data 8'h3C, reset pulsed one cycle -> out_valid=0, out_data=0, next round-robin grant goes to ch0.
REQ-036 The bench SHALL cover the counter with CHAN_SELECT_MUX_COUNT_EN defined: 5 transfers -> xfer_count=5; preload near 16'hFFFF with 3 more transfers -> xfer_count stays 16'hFFFF.
